frame_window_buffer: RTL
========================

// Module: frame_window_buffer
// PURPOSE
//  Parametrised overlapping-frame buffer for the MFCC front end. Sits between the sample FIFO and the
//  windowing/FFT stage. Collects FRAME_LEN samples, streams the frame oldest->newest over ready/valid,
//  then accepts HOP_LEN new samples that overwrite the oldest and streams the next frame.
//  Overlap is FRAME_LEN-HOP_LEN samples.
// PARAMETERS
//  WIDTH      16   sample width in bits
//  FRAME_LEN  400  samples per frame (buffer depth)
//  HOP_LEN    160  new samples per frame; 1 <= HOP_LEN <= FRAME_LEN, else $error at elaboration
//  CNT_W      16   width of frame_count_o
//  (localparam ADDR_W = $clog2(FRAME_LEN))
// PORTS
//  clk            in   1       clock
//  rst            in   1       synchronous reset, active-high
//  in_valid_i     in   1       input sample valid (FIFO not empty)
//  in_data_i      in   WIDTH   input sample
//  in_ready_o     out  1       sample accepted when in_valid_i && in_ready_o (drives FIFO rd_en)
//  out_valid_o    out  1       frame sample valid
//  out_data_o     out  WIDTH   frame sample
//  out_idx_o      out  ADDR_W  position of sample within frame, 0..FRAME_LEN-1
//  out_last_o     out  1       high with the FRAME_LEN-1 sample
//  out_ready_i    in   1       consumer ready
//  frame_start_o  out  1       one-cycle pulse on entry to EMIT
//  frame_count_o  out  CNT_W   frames fully emitted, wraps modulo 2^CNT_W
//  flush_i        in   1       only with FWB_FLUSH_EN: pad current frame with zeros and emit
// BEHAVIOUR
//  - Reset: state FILL, wr_ptr=0, fill_cnt=0, rd_cnt=0, frame_count_o=0, frame_start_o=0.
//    Buffer contents are not cleared. A reset mid-frame abandons the frame; the next cycle is FILL with an empty count.
//  - FILL: in_ready_o=1. Each accept writes mem[wr_ptr] and increments fill_cnt. wr_ptr wraps FRAME_LEN-1 -> 0
//    by compare; no modulo. The accept that makes fill_cnt==FRAME_LEN goes to EMIT.
//  - EMIT: in_ready_o=0, out_valid_o=1.
//    - Read address is wr_ptr+rd_cnt, wrapped by compare; wr_ptr marks the oldest sample. Read is combinational.
//    - out_idx_o=rd_cnt.
//    - Transfer on out_valid_o && out_ready_i. rd_cnt increments.
//    - When out_ready_i=0, out_data_o, out_idx_o and out_last_o hold stable.
//    - Last transfer: rd_cnt->0, frame_count_o+1, fill_cnt->0, go to HOP.
//  - HOP: in_ready_o=1, out_valid_o=0. The accept that makes fill_cnt==HOP_LEN goes to EMIT. wr_ptr then again marks the oldest sample.
//  - HOP_LEN==FRAME_LEN gives non-overlapping frames. HOP is then identical to FILL in length.
//  - frame_start_o: registered, high exactly the first cycle in EMIT.
//  - Latency: the first frame sample is valid the cycle after the accept that completes the frame.
//    Throughput is 1 sample/cycle each direction, never simultaneously.
//  - in_valid_i is ignored while in_ready_o=0. FIFO empty (in_valid_i=0) simply stalls FILL/HOP.
// CONFIGURATION
//  - FWB_FLUSH_EN defined: adds flush_i and state PAD.
//    - flush_i is sampled in FILL/HOP with fill_cnt>0, or with a same-cycle accept.
//    - A same-cycle accept is written first. Then go to PAD.
//    - PAD: in_ready_o=0. Writes 0 at wr_ptr per cycle until the frame is complete, then EMIT.
//    - After that frame's last transfer, go to FILL, not HOP, so a fresh stream starts.
//    - flush_i is ignored in EMIT/PAD and in FILL/HOP with fill_cnt==0 and no accept.
//  - FWB_FLUSH_EN undefined: no flush_i port, no PAD state. Behaviour exactly as above.
// STRUCTURE
//  - Shared package frame_buffer_pkg holds:
//    - fwb_state_t enum {FILL, EMIT, HOP, PAD}
//    - function wrap_add(ptr, inc, len) for compare-based modulo
//  - One sub-module, frame_ram: WIDTH x FRAME_LEN register array, one sync write port, one combinational read port.
//  - FSM, pointers and counters stay in frame_window_buffer.
// TESTING  (bench FRAME_LEN=8, HOP_LEN=3, WIDTH=16, input samples 1,2,3,...)
//  - Stream 8 samples, out_ready_i=1 -> frame_start_o pulse. Out 1..8, idx 0..7, out_last_o on 8. frame_count_o=1.
//  - Continue 3 samples -> frame 2 is 4..11, frame 3 is 7..14. in_ready_o=0 throughout EMIT.
//  - Toggle out_ready_i randomly in EMIT -> data/idx stable while stalled. No loss or duplication. Same sequence as above.
//  - in_valid_i gaps of 0-5 cycles in FILL/HOP -> identical frame contents. No spurious out_valid_o.
//  - Assert rst at idx 4 of frame 2 -> next cycle FILL, frame_count_o=0. Next 8 samples form a clean frame.
//  - FWB_FLUSH_EN: flush_i after 5 samples in FILL -> frame 1,2,3,4,5,0,0,0. Then FILL. Next frame is new samples only.
//  - HOP_LEN=8 build -> consecutive frames 1..8 and 9..16.

Source files
------------

// File: rtl/frame_buffer_pkg.sv
// Shared types and helpers for the overlapping-frame buffer.
// Provides the FSM state enum and a compare-based modulo add for circular pointers.
package frame_buffer_pkg;

    typedef enum logic [1:0] {FILL, EMIT, HOP, PAD} fwb_state_t;

    // Caller guarantees ptr < len and inc < len, so a single subtract suffices.
    function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned inc,
                                             input int unsigned len);
        int unsigned sum;
        sum = ptr + inc;
        return (sum >= len) ? (sum - len) : sum;
    endfunction

endpackage

// File: rtl/frame_ram.sv
// Sample store for frame_window_buffer: WIDTH x DEPTH registers,
// one synchronous write port and one combinational read port. Contents are never reset.
module frame_ram #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 400,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/frame_window_buffer.sv
// Overlapping-frame buffer: collects FRAME_LEN samples, streams them oldest->newest, then takes
// HOP_LEN fresh samples per frame. Define FWB_FLUSH_EN to add flush_i and the zero-padding PAD state.
module frame_window_buffer
    import frame_buffer_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned FRAME_LEN = 400,
    parameter int unsigned HOP_LEN   = 160,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned ADDR_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [WIDTH-1:0]  in_data_i,
    output logic              in_ready_o,
    output logic              out_valid_o,
    output logic [WIDTH-1:0]  out_data_o,
    output logic [ADDR_W-1:0] out_idx_o,
    output logic              out_last_o,
    input  logic              out_ready_i,
    output logic              frame_start_o,
`ifdef FWB_FLUSH_EN
    input  logic              flush_i,
`endif
    output logic [CNT_W-1:0]  frame_count_o
);

    localparam int unsigned       FILL_W   = $clog2(FRAME_LEN + 1);
    localparam logic [FILL_W-1:0] FrameCnt = FILL_W'(FRAME_LEN);
    localparam logic [FILL_W-1:0] HopCnt   = FILL_W'(HOP_LEN);
    localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(FRAME_LEN - 1);

    if (HOP_LEN < 1 || HOP_LEN > FRAME_LEN) begin : g_bad_hop
        $error("frame_window_buffer: HOP_LEN must lie in 1..FRAME_LEN");
    end

    fwb_state_t        r_state, w_state_d;
    logic [ADDR_W-1:0] r_wr_ptr, w_wr_ptr_d, w_wr_ptr_inc;
    logic [ADDR_W-1:0] r_rd_cnt, w_rd_cnt_d, w_rd_addr;
    logic [FILL_W-1:0] r_fill_cnt, w_fill_cnt_d, w_target;
    logic [CNT_W-1:0]  r_frame_count, w_frame_count_d;
    logic              r_frame_start;
    logic              w_wr_en;
    logic [WIDTH-1:0]  w_wr_data, w_rd_data;
`ifdef FWB_FLUSH_EN
    logic              r_flushed, w_flushed_d;
    logic              r_pad_hop, w_pad_hop_d;
    logic              w_flush_take;

    // A padded frame completes at the hop count if the flush interrupted a hop.
    assign w_target     = (r_state == HOP || (r_state == PAD && r_pad_hop)) ? HopCnt : FrameCnt;
    assign w_flush_take = flush_i && (r_fill_cnt != '0 || in_valid_i);
`else
    assign w_target = (r_state == HOP) ? HopCnt : FrameCnt;
`endif

    // wr_ptr always points at the oldest sample once a frame is complete.
    assign w_wr_ptr_inc = ADDR_W'(wrap_add(32'(r_wr_ptr), 32'd1, FRAME_LEN));
    assign w_rd_addr    = ADDR_W'(wrap_add(32'(r_wr_ptr), 32'(r_rd_cnt), FRAME_LEN));

    always_comb begin
        w_state_d       = r_state;
        w_wr_ptr_d      = r_wr_ptr;
        w_fill_cnt_d    = r_fill_cnt;
        w_rd_cnt_d      = r_rd_cnt;
        w_frame_count_d = r_frame_count;
        w_wr_en         = 1'b0;
        w_wr_data       = in_data_i;
        in_ready_o      = 1'b0;
        out_valid_o     = 1'b0;
`ifdef FWB_FLUSH_EN
        w_flushed_d     = r_flushed;
        w_pad_hop_d     = r_pad_hop;
`endif
        unique case (r_state)
            FILL, HOP: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_wr_en      = 1'b1;
                    w_wr_ptr_d   = w_wr_ptr_inc;
                    w_fill_cnt_d = r_fill_cnt + 1'b1;
                end
                if (w_fill_cnt_d == w_target) begin
                    w_state_d = EMIT;
                end
`ifdef FWB_FLUSH_EN
                if (w_flush_take) begin
                    w_flushed_d = 1'b1;
                    w_pad_hop_d = (r_state == HOP);
                    if (w_fill_cnt_d != w_target) begin
                        w_state_d = PAD;
                    end
                end
`endif
            end
            EMIT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    if (r_rd_cnt == LastIdx) begin
                        w_rd_cnt_d      = '0;
                        w_fill_cnt_d    = '0;
                        w_frame_count_d = r_frame_count + 1'b1;
                        w_state_d       = HOP;
`ifdef FWB_FLUSH_EN
                        if (r_flushed) begin
                            w_state_d   = FILL;
                            w_flushed_d = 1'b0;
                        end
`endif
                    end else begin
                        w_rd_cnt_d = r_rd_cnt + 1'b1;
                    end
                end
            end
`ifdef FWB_FLUSH_EN
            PAD: begin
                w_wr_en      = 1'b1;
                w_wr_data    = '0;
                w_wr_ptr_d   = w_wr_ptr_inc;
                w_fill_cnt_d = r_fill_cnt + 1'b1;
                if (w_fill_cnt_d == w_target) begin
                    w_state_d = EMIT;
                end
            end
`endif
            default: w_state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FILL;
            r_wr_ptr      <= '0;
            r_fill_cnt    <= '0;
            r_rd_cnt      <= '0;
            r_frame_count <= '0;
            r_frame_start <= 1'b0;
`ifdef FWB_FLUSH_EN
            r_flushed     <= 1'b0;
            r_pad_hop     <= 1'b0;
`endif
        end else begin
            r_state       <= w_state_d;
            r_wr_ptr      <= w_wr_ptr_d;
            r_fill_cnt    <= w_fill_cnt_d;
            r_rd_cnt      <= w_rd_cnt_d;
            r_frame_count <= w_frame_count_d;
            r_frame_start <= (w_state_d == EMIT) && (r_state != EMIT);
`ifdef FWB_FLUSH_EN
            r_flushed     <= w_flushed_d;
            r_pad_hop     <= w_pad_hop_d;
`endif
        end
    end

    frame_ram #(
        .WIDTH (WIDTH),
        .DEPTH (FRAME_LEN),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk      (clk),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(w_wr_data),
        .i_rd_addr(w_rd_addr),
        .o_rd_data(w_rd_data)
    );

    assign out_data_o    = w_rd_data;
    assign out_idx_o     = r_rd_cnt;
    assign out_last_o    = out_valid_o && (r_rd_cnt == LastIdx);
    assign frame_start_o = r_frame_start;
    assign frame_count_o = r_frame_count;

endmodule
